moonbase_bus_responder: RTL and testbench

- Target side of the moonbase 4-bit CPU's multiplexed 8-bit bus.
- Replaces the external 7-bit address latch, the 256-nibble code/data SRAM and the device I/O glue with one on-die block.
- Decodes the CPU's bus word each clock and returns the CPU's input nibble and its 2-bit device-input field.
- Optionally lets a host load code memory while the CPU is held in reset.

---
 rtl/moonbase_bus_responder_pkg.sv | 10 +
 rtl/moonbase_bus_responder_nibble_ram.sv | 16 +
 rtl/moonbase_bus_responder.sv | 115 +++++++++++
 tb/tb_moonbase_bus_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/moonbase_bus_responder_pkg.sv
// moonbase_pkg: shared bus bit positions, memory map constants and loader state type.
package moonbase_pkg;
  localparam int STROBE_BIT   = 7;
  localparam int CODE_SEL_BIT = 6;
  localparam int WR_RAM_N_BIT = 5;
  localparam int WR_DEV_N_BIT = 4;
  localparam int MEM_DEPTH    = 256;
  localparam logic [7:0] CODE_BASE = 8'd128;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_e;
endpackage

// File: rtl/moonbase_bus_responder_nibble_ram.sv
// moonbase_nibble_ram: 256x4 nibble store, combinational read, one synchronous write port.
module moonbase_nibble_ram
  import moonbase_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [3:0] rdata_o
);
  logic [3:0] mem_q [MEM_DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/moonbase_bus_responder.sv
// moonbase_bus_responder: address latch, code/data nibble RAM and device I/O behind the moonbase CPU bus.
// Define MOONBASE_LOADER_EN to build the host code loader that fills code memory while the CPU is held in reset.
module moonbase_bus_responder
  import moonbase_pkg::*;
#(
  parameter int N_DEV_OUT = 8,
  parameter int N_DEV_IN  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              bus_out,
  output logic [3:0]              ram_in,
  output logic [1:0]              data_in,
  input  logic [2*N_DEV_IN-1:0]   dev_in,
  output logic [4*N_DEV_OUT-1:0]  dev_out,
  output logic                    cpu_reset,
  input  logic                    load_valid,
  input  logic [3:0]              load_data,
  output logic                    load_ready,
  input  logic                    load_start
);
  logic [6:0] latch_q;
  logic [3:0] dev_q [N_DEV_OUT];
  logic [2*N_DEV_IN-1:0] sync1_q, sync2_q;
  logic cpu_reset_q;
  logic strobe, cpu_wr_ram, cpu_wr_dev, ld_we, we;
  logic [7:0] ea, waddr, ld_addr;
  logic [3:0] wdata;
  assign strobe     = bus_out[STROBE_BIT];
  assign ea         = {~strobe & bus_out[CODE_SEL_BIT], latch_q};
  assign cpu_wr_ram = ~strobe & ~bus_out[WR_RAM_N_BIT];
  assign cpu_wr_dev = ~strobe & ~bus_out[WR_DEV_N_BIT];
  always_ff @(posedge clk)
    if (!reset_n) latch_q <= '0;
    else if (strobe) latch_q <= bus_out[6:0];
  always_ff @(posedge clk)
    for (int i = 0; i < N_DEV_OUT; i++)
      dev_q[i] <= !reset_n ? 4'h0 : (cpu_wr_dev && latch_q[2:0] == 3'(i)) ? bus_out[3:0] : dev_q[i];
  for (genvar d = 0; d < N_DEV_OUT; d++) begin : g_dev
    assign dev_out[4*d +: 4] = dev_q[d];
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dev_in;
      sync2_q <= sync1_q;
    end
  always_comb begin
    data_in = 2'b00;
    for (int i = 0; i < N_DEV_IN; i++)
      if (latch_q[1:0] == 2'(i)) data_in = sync2_q[2*i +: 2];
  end
`ifdef MOONBASE_LOADER_EN
  load_state_e state_q;
  logic [7:0] ptr_q;
  logic load_ready_q;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= CODE_BASE;
      load_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cpu_reset_q <= load_start;
          if (load_start) begin
            state_q      <= LOAD;
            ptr_q        <= CODE_BASE;
            load_ready_q <= 1'b1;
          end
        end
        LOAD:
          if (load_valid && load_ready_q) begin
            ptr_q <= ptr_q + 8'd1;
            if (ptr_q == 8'hFF) begin
              state_q      <= DONE;
              load_ready_q <= 1'b0;
            end
          end
        DONE: begin
          state_q     <= IDLE;
          cpu_reset_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign ld_we      = (state_q == LOAD) & load_valid & load_ready_q;
  assign ld_addr    = ptr_q;
  assign load_ready = load_ready_q;
`else
  logic unused_load;
  assign unused_load = ^{load_valid, load_data, load_start};
  always_ff @(posedge clk)
    cpu_reset_q <= !reset_n;
  assign ld_we      = 1'b0;
  assign ld_addr    = CODE_BASE;
  assign load_ready = 1'b0;
`endif
  // reset wins over any write presented in the same cycle
  assign we    = reset_n & (ld_we | cpu_wr_ram);
  assign waddr = ld_we ? ld_addr : ea;
  assign wdata = ld_we ? load_data : bus_out[3:0];
  moonbase_nibble_ram u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (ea),
    .rdata_o (ram_in)
  );
  assign cpu_reset = cpu_reset_q;
endmodule

// File: tb/tb_moonbase_bus_responder.sv
// tb_moonbase_bus_responder: directed table plus hand sequences for latch, RAM, device I/O, reset and loader.
module tb_moonbase_bus_responder;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] bus_out;
  logic [7:0] dev_in;
  logic load_valid, load_start;
  logic [3:0] load_data;
  logic [3:0] ram_in, ram_in2;
  logic [1:0] data_in, data_in2;
  logic [31:0] dev_out;
  logic [7:0] dev_out2;
  logic cpu_reset, cpu_reset2, load_ready, load_ready2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  moonbase_bus_responder dut (
    .clk(clk), .reset_n(reset_n), .bus_out(bus_out), .ram_in(ram_in), .data_in(data_in),
    .dev_in(dev_in), .dev_out(dev_out), .cpu_reset(cpu_reset), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_start(load_start)
  );

  moonbase_bus_responder #(.N_DEV_OUT(2), .N_DEV_IN(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus_out(bus_out), .ram_in(ram_in2), .data_in(data_in2),
    .dev_in(dev_in[3:0]), .dev_out(dev_out2), .cpu_reset(cpu_reset2), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready2), .load_start(load_start)
  );

  typedef struct {
    logic [7:0]  bus;
    logic        cr;
    logic [3:0]  ram;
    logic [31:0] dev;
    logic [7:0]  dev2;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] w);
    bus_out = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{8'h85, 1'b0, 4'h0, 32'h0000_0000, 8'h00},
      '{8'h5A, 1'b0, 4'h0, 32'h0000_0000, 8'h00},
      '{8'h40, 1'b1, 4'hA, 32'h0000_0000, 8'h00},
      '{8'h83, 1'b0, 4'h0, 32'h0000_0000, 8'h00},
      '{8'h07, 1'b0, 4'h0, 32'h0000_0000, 8'h00},
      '{8'h83, 1'b1, 4'h7, 32'h0000_7000, 8'h00},
      '{8'h10, 1'b1, 4'h7, 32'h0000_7000, 8'h00},
      '{8'h82, 1'b1, 4'h0, 32'h0000_7000, 8'h00},
      '{8'h29, 1'b0, 4'h0, 32'h0000_7000, 8'h00},
      '{8'h8A, 1'b0, 4'h0, 32'h0000_7900, 8'h00},
      '{8'h25, 1'b0, 4'h0, 32'h0000_7900, 8'h00},
      '{8'h81, 1'b0, 4'h0, 32'h0000_7500, 8'h00},
      '{8'h2C, 1'b0, 4'h0, 32'h0000_7500, 8'h00},
      '{8'h70, 1'b0, 4'h0, 32'h0000_75C0, 8'hC0}
    };
    reset_n = 1'b0; bus_out = 8'h70; dev_in = 8'h00;
    load_valid = 1'b0; load_start = 1'b0; load_data = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_cpu_reset", cpu_reset, 1);
    chk("reset_dev_out", dev_out, 0);
    chk("reset_load_ready", load_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("cpu_reset_after_release", cpu_reset, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cpu_reset_drops", cpu_reset, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      bus_out = tbl[i].bus;
      @(negedge clk);
      if (tbl[i].cr) chk($sformatf("ram_in[%0d]", i), ram_in, tbl[i].ram);
      chk($sformatf("dev_out[%0d]", i), dev_out, tbl[i].dev);
      chk($sformatf("dev_out_n2[%0d]", i), dev_out2, tbl[i].dev2);
      @(posedge clk); #1;
    end

    // synchronizer latency: latch[1:0]=1 selects dev_in[3:2]
    dev_in = 8'b0000_1000;
    @(negedge clk);
    chk("din_t0", data_in, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("din_t1", data_in, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("din_t2", data_in, 2'b10);
    chk("din_t2_n2", data_in2, 2'b10);
    @(posedge clk); #1;
    dev_in = 8'b0000_1011;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("din_other_pair", data_in, 2'b10);
    @(posedge clk); #1;
    dev_in = 8'b1100_1011;
    drive(8'h83);
    bus_out = 8'h70;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("din_pair3", data_in, 2'b11);
    chk("din_pair3_n2_oob", data_in2, 2'b00);
    @(posedge clk); #1;

    // reset in the same cycle as a write to address 9
    drive(8'h80); drive(8'h1E); drive(8'h89); drive(8'h1C); drive(8'h89);
    bus_out = 8'h05; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; bus_out = 8'h30;
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_dev_out", dev_out, 0);
    chk("rst_latch_zero", ram_in, 4'hE);
    chk("rst_sync_clear", data_in, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cpu_reset_drop", cpu_reset, 0);
    @(posedge clk); #1;
    drive(8'h89);
    bus_out = 8'h30;
    @(negedge clk);
    chk("rst_mem9_kept", ram_in, 4'hC);
    @(posedge clk); #1;

`ifdef MOONBASE_LOADER_EN
    begin
      int n;
      logic hs, cr_bad, rdy_bad;
      n = 0; cr_bad = 1'b0; rdy_bad = 1'b0;
      bus_out = 8'h70;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      chk("ld_ready_up", load_ready, 1);
      chk("ld_cpu_reset_up", cpu_reset, 1);
      @(posedge clk); #1;
      for (int k = 0; k < 600 && n < 128; k++) begin
        load_valid = (k % 4) != 3;
        load_data  = n[3:0];
        load_start = (k == 10);
        @(negedge clk);
        if (cpu_reset !== 1'b1) cr_bad = 1'b1;
        if (load_ready !== 1'b1) rdy_bad = 1'b1;
        hs = load_valid & load_ready;
        @(posedge clk); #1;
        if (hs) n++;
      end
      load_valid = 1'b0; load_start = 1'b0;
      chk("ld_count", n, 128);
      chk("ld_cpu_reset_held", cr_bad, 0);
      chk("ld_ready_held", rdy_bad, 0);
      @(negedge clk);
      chk("ld_done_ready", load_ready, 0);
      chk("ld_done_cpu_reset", cpu_reset, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ld_cpu_reset_drop", cpu_reset, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 128; i++) begin
        drive(8'h80 | 8'(i));
        bus_out = 8'h70;
        @(negedge clk);
        chk($sformatf("ld_mem[%0d]", 128 + i), ram_in, 4'(i));
        @(posedge clk); #1;
      end
    end
`else
    load_start = 1'b1; load_valid = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    chk("noload_ready", load_ready, 0);
    chk("noload_cpu_reset", cpu_reset, 0);
    @(posedge clk); #1;
    load_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
